alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/issue stage feeding the integer ALU: accepts a fetched instruction word plus PC and drives regfile read addresses.
- Generates immediates and ALU controls (funct7, funct3, A, B), then registers them in an ID/EX pipeline register with a valid/ready handshake.
- Sits between fetch and the ALU/EX stage. Produces exactly the operand/control encoding the ALU consumes; supports stall and flush.

Parameters:
- XLEN, 32, operand/PC width
- RESET_PC, 32'h0000_0000, reset value of registered ex_pc

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- rs1_addr  out  5  regfile read address, = in_instr[19:15], combinational
- rs2_addr  out  5  regfile read address, = in_instr[24:20], combinational
- rs1_data  in  XLEN  regfile read data, same cycle
- rs2_data  in  XLEN  regfile read data, same cycle
- flush  in  1  kill registered and incoming instruction
- wb_valid  in  1  writeback valid (used only with ALU_FWD_EN)
- wb_rd  in  5  writeback destination (used only with ALU_FWD_EN)
- wb_data  in  XLEN  writeback data (used only with ALU_FWD_EN)
- ex_ready  in  1  ALU/EX stage accepts
- ex_valid  out  1  registered instruction valid
- ex_funct7  out  7  ALU funct7
- ex_funct3  out  3  ALU funct3
- ex_a  out  XLEN  ALU operand A
- ex_b  out  XLEN  ALU operand B
- ex_rd  out  5  destination register
- ex_we  out  1  register write enable
- ex_illegal  out  1  unsupported or illegal encoding
- ex_pc  out  XLEN  PC of issued instruction

Behaviour:
- Reset (async): ex_valid=0, ex_we=0, ex_illegal=0, ex_funct7=0, ex_funct3=0, ex_a=0, ex_b=0, ex_rd=0, ex_pc=RESET_PC. Reset mid-transfer discards everything.
- in_ready = ~ex_valid | ex_ready (combinational, no dependence on in_valid).
- Accept = in_valid & in_ready & ~flush. On accept, all ex_* outputs load the decode of in_instr; latency is 1 cycle.
- If ex_valid & ~ex_ready, all ex_* outputs hold stable.
- If ex_ready & ~accept, ex_valid clears to 0.
- flush has priority over everything: next cycle ex_valid=0 and the incoming instruction is dropped.
- Decode, by opcode:
  - OP (0110011): A=rs1, B=rs2, funct3=instr[14:12], funct7=instr[31:25].
    - Legal only if funct7=0000000, or funct7=0100000 with funct3 000 or 101.
  - OP-IMM (0010011): A=rs1, B=sign-extended instr[31:20].
    - funct3=001: legal only if instr[31:25]=0; funct7=0.
    - funct3=101: funct7=instr[31:25]; legal only if it is 0000000 or 0100000; B[4:0]=shamt.
    - All other funct3: funct7 forced to 0, so ADDI never subtracts.
  - LUI (0110111): A=0, B={instr[31:12],12'b0}, funct3=000, funct7=0.
  - AUIPC (0010111): A=in_pc, B={instr[31:12],12'b0}, funct3=000, funct7=0.
  - Any other opcode: ex_illegal=1, ex_we=0, funct3/funct7=0. The instruction is still issued (ex_valid=1) so the trap logic sees it.
- ex_we = legal & (rd != 0).
- Illegal encodings within OP/OP-IMM also force ex_we=0.
- All sign extension is to XLEN; PC is not modified.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: writeback bypass. If wb_valid & wb_rd!=0 & wb_rd==rs1_addr, the rs1 value is replaced by wb_data; the same applies independently for rs2. Bypass applies only where the operand is a register source.
- Undefined: wb_* ports exist but are ignored; operands come from rs1_data/rs2_data only.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), rs1_data=0, ex_ready=1 -> next cycle ex_valid=1, funct3=000, funct7=0, ex_b=0xFFFFFFFB, ex_rd=1, ex_we=1.
- SRAI x2,x1,3 (0x4030D113), rs1_data=0x80000000 -> funct3=101, funct7=0x20, ex_b[4:0]=3, ex_a=0x80000000; SUB x3,x1,x2 (0x402081B3) -> funct7=0x20, funct3=000, ex_b=rs2_data.
- LUI x5,0x12345 (0x123452B7) -> ex_a=0, ex_b=0x12345000; AUIPC with in_pc=0x100, imm 0x1 -> ex_a=0x100, ex_b=0x1000.
- Hold ex_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ex_* stable; release -> next instruction issued one cycle after.
- Assert flush with ex_valid=1 and in_valid=1 -> next cycle ex_valid=0; rst pulsed mid-stall -> all outputs at reset values immediately.
- Opcode 0x7F, or OP with funct7=0x01 -> ex_illegal=1, ex_we=0, ex_valid=1. With ALU_FWD_EN: wb_rd=1, wb_data=0x55 and rs1=x1 -> ex_a=0x55; wb_rd=0 -> no bypass.

Source files
------------

// File: rtl/alu_issue_if.sv
// Fetch/regfile/EX-facing signal bundle for alu_issue_stage.
// The slave modport is the stage's view; master is the surrounding pipeline's view.
interface alu_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_ready;
  logic            ex_valid;
  logic [6:0]      ex_funct7;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [4:0]      ex_rd;
  logic            ex_we;
  logic            ex_illegal;
  logic [XLEN-1:0] ex_pc;

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush,
           wb_valid, wb_rd, wb_data, ex_ready,
    output in_ready, rs1_addr, rs2_addr, ex_valid, ex_funct7, ex_funct3,
           ex_a, ex_b, ex_rd, ex_we, ex_illegal, ex_pc
  );

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush,
           wb_valid, wb_rd, wb_data, ex_ready,
    input  in_ready, rs1_addr, rs2_addr, ex_valid, ex_funct7, ex_funct3,
           ex_a, ex_b, ex_rd, ex_we, ex_illegal, ex_pc
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU controls and registers them in ID/EX.
// Define ALU_FWD_EN to enable the writeback-to-operand bypass.
module alu_issue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } ex_t;

  ex_t             ex_q, ex_d, dec;
  logic            valid_q, valid_d;
  logic            accept;
  logic            legal;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] i_imm, u_imm;
  logic [6:0]      opcode, f7_raw;
  logic [2:0]      f3_raw;

  assign opcode = bus.in_instr[6:0];
  assign f3_raw = bus.in_instr[14:12];
  assign f7_raw = bus.in_instr[31:25];
  assign i_imm  = XLEN'($signed(bus.in_instr[31:20]));
  assign u_imm  = XLEN'($signed({bus.in_instr[31:12], 12'b0}));

  assign bus.rs1_addr = bus.in_instr[19:15];
  assign bus.rs2_addr = bus.in_instr[24:20];

`ifdef ALU_FWD_EN
  // Writeback bypass: register file has not yet absorbed the value being written.
  always_comb begin
    rs1_val = bus.rs1_data;
    rs2_val = bus.rs2_data;
    if (bus.wb_valid && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rs1_addr)) rs1_val = bus.wb_data;
    if (bus.wb_valid && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rs2_addr)) rs2_val = bus.wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_valid, bus.wb_rd, bus.wb_data};
  assign rs1_val   = bus.rs1_data;
  assign rs2_val   = bus.rs2_data;
`endif

  // Instruction decode into the ALU operand/control encoding.
  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    dec.rd = bus.in_instr[11:7];
    dec.pc = bus.in_pc;
    unique case (opcode)
      OPC_OP: begin
        dec.a      = rs1_val;
        dec.b      = rs2_val;
        dec.funct3 = f3_raw;
        dec.funct7 = f7_raw;
        legal      = (f7_raw == F7_ZERO) ||
                     ((f7_raw == F7_ALT) && ((f3_raw == 3'b000) || (f3_raw == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.a      = rs1_val;
        dec.b      = i_imm;
        dec.funct3 = f3_raw;
        if (f3_raw == 3'b001) begin
          legal = (f7_raw == F7_ZERO);
        end else if (f3_raw == 3'b101) begin
          dec.funct7 = f7_raw;
          legal      = (f7_raw == F7_ZERO) || (f7_raw == F7_ALT);
        end
      end
      OPC_LUI: begin
        dec.b = u_imm;
      end
      OPC_AUIPC: begin
        dec.a = bus.in_pc;
        dec.b = u_imm;
      end
      default: legal = 1'b0;
    endcase
    dec.illegal = ~legal;
    dec.we      = legal && (dec.rd != 5'd0);
  end

  assign bus.in_ready = ~valid_q | bus.ex_ready;
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

  // ID/EX next-state: flush beats accept beats drain; otherwise hold.
  always_comb begin
    valid_d = valid_q;
    ex_d    = ex_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ex_d    = dec;
    end else if (bus.ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ex_q     <= '0;
      ex_q.pc  <= RESET_PC;
    end else begin
      valid_q  <= valid_d;
      ex_q     <= ex_d;
    end
  end

  assign bus.ex_valid   = valid_q;
  assign bus.ex_funct7  = ex_q.funct7;
  assign bus.ex_funct3  = ex_q.funct3;
  assign bus.ex_a       = ex_q.a;
  assign bus.ex_b       = ex_q.b;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_we      = ex_q.we;
  assign bus.ex_illegal = ex_q.illegal;
  assign bus.ex_pc      = ex_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; expected values are hand-decoded.
// Honours ALU_FWD_EN for the bypass expectations.
module tb_alu_issue_stage;

  localparam logic [31:0] RST_PC = 32'hDEAD_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input logic v, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic we, input logic ill);
    chk({tag, ".valid"},   32'(bus.ex_valid),   32'(v));
    chk({tag, ".funct7"},  32'(bus.ex_funct7),  32'(f7));
    chk({tag, ".funct3"},  32'(bus.ex_funct3),  32'(f3));
    chk({tag, ".a"},       bus.ex_a,            a);
    chk({tag, ".b"},       bus.ex_b,            b);
    chk({tag, ".rd"},      32'(bus.ex_rd),      32'(rd));
    chk({tag, ".we"},      32'(bus.ex_we),      32'(we));
    chk({tag, ".illegal"}, 32'(bus.ex_illegal), 32'(ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.rs1_data = d1;
    bus.rs2_data = d2;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.in_pc    = 32'h0;
    bus.rs1_data = 32'h0;
    bus.rs2_data = 32'h0;
    bus.flush    = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'h0;
    bus.ex_ready = 1'b1;
    #3;
    chk_ex("reset", 1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("reset.pc", bus.ex_pc, RST_PC);
    chk("reset.in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ADDI x1,x0,-5
    drive(32'hFFB0_0093, 32'h10, 32'h0, 32'h1234);
    #1;
    chk("addi.rs1_addr", 32'(bus.rs1_addr), 32'h00);
    chk("addi.rs2_addr", 32'(bus.rs2_addr), 32'h1B);
    tick();
    chk_ex("addi", 1'b1, 7'h00, 3'b000, 32'h0, 32'hFFFF_FFFB, 5'd1, 1'b1, 1'b0);
    chk("addi.pc", bus.ex_pc, 32'h10);

    // SRAI x2,x1,3
    drive(32'h4030_D113, 32'h14, 32'h8000_0000, 32'h0);
    tick();
    chk_ex("srai", 1'b1, 7'h20, 3'b101, 32'h8000_0000, 32'h0000_0403, 5'd2, 1'b1, 1'b0);

    // SUB x3,x1,x2
    drive(32'h4020_81B3, 32'h18, 32'h7, 32'h99);
    tick();
    chk_ex("sub", 1'b1, 7'h20, 3'b000, 32'h7, 32'h99, 5'd3, 1'b1, 1'b0);

    // ADDI x1,x1,-1024: upper imm bits must not leak into funct7
    drive(32'hC000_8093, 32'h1C, 32'h5, 32'h0);
    tick();
    chk_ex("addi_neg", 1'b1, 7'h00, 3'b000, 32'h5, 32'hFFFF_FC00, 5'd1, 1'b1, 1'b0);

    // LUI x5,0x12345
    drive(32'h1234_52B7, 32'h20, 32'hAAAA, 32'h0);
    tick();
    chk_ex("lui", 1'b1, 7'h00, 3'b000, 32'h0, 32'h1234_5000, 5'd5, 1'b1, 1'b0);

    // AUIPC x6,0x1 at pc 0x100
    drive(32'h0000_1317, 32'h100, 32'hBBBB, 32'h0);
    tick();
    chk_ex("auipc", 1'b1, 7'h00, 3'b000, 32'h100, 32'h1000, 5'd6, 1'b1, 1'b0);
    chk("auipc.pc", bus.ex_pc, 32'h100);

    // Stall three cycles with ADDI x7,x0,1 pending
    drive(32'h0010_0393, 32'h104, 32'h0, 32'h0);
    bus.ex_ready = 1'b0;
    #1;
    chk("stall.in_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ex("stall", 1'b1, 7'h00, 3'b000, 32'h100, 32'h1000, 5'd6, 1'b1, 1'b0);
      chk("stall.pc", bus.ex_pc, 32'h100);
      chk("stall.in_ready_hold", 32'(bus.in_ready), 32'h0);
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk_ex("release", 1'b1, 7'h00, 3'b000, 32'h0, 32'h1, 5'd7, 1'b1, 1'b0);

    // Flush with a valid registered instruction and a new one incoming
    drive(32'h0010_0413, 32'h108, 32'h0, 32'h0);
    bus.flush = 1'b1;
    tick();
    chk("flush.valid", 32'(bus.ex_valid), 32'h0);
    bus.flush = 1'b0;

    // Unknown opcode 0x7F, rd=31
    drive(32'h0000_0FFF, 32'h10C, 32'h1, 32'h2);
    tick();
    chk("ill_opc.valid",   32'(bus.ex_valid),   32'h1);
    chk("ill_opc.illegal", 32'(bus.ex_illegal), 32'h1);
    chk("ill_opc.we",      32'(bus.ex_we),      32'h0);
    chk("ill_opc.funct3",  32'(bus.ex_funct3),  32'h0);
    chk("ill_opc.funct7",  32'(bus.ex_funct7),  32'h0);

    // OP with funct7=0x01
    drive(32'h0220_84B3, 32'h110, 32'h1, 32'h2);
    tick();
    chk("ill_op.valid",   32'(bus.ex_valid),   32'h1);
    chk("ill_op.illegal", 32'(bus.ex_illegal), 32'h1);
    chk("ill_op.we",      32'(bus.ex_we),      32'h0);

    // SLLI with nonzero upper bits
    drive(32'h4010_9093, 32'h114, 32'h1, 32'h0);
    tick();
    chk("ill_slli.illegal", 32'(bus.ex_illegal), 32'h1);
    chk("ill_slli.we",      32'(bus.ex_we),      32'h0);

    // No input while EX ready: valid drains
    bus.in_valid = 1'b0;
    tick();
    chk("drain.valid", 32'(bus.ex_valid), 32'h0);

    // Bypass: ADDI x10,x1,0 with writeback to x1
    drive(32'h0000_8513, 32'h118, 32'h11, 32'h0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.wb_data  = 32'h55;
    tick();
`ifdef ALU_FWD_EN
    chk("fwd.a", bus.ex_a, 32'h55);
`else
    chk("fwd.a", bus.ex_a, 32'h11);
`endif
    // wb_rd=0 never bypasses
    drive(32'h0000_0513, 32'h11C, 32'h22, 32'h0);
    bus.wb_rd = 5'd0;
    tick();
    chk("fwd_x0.a", bus.ex_a, 32'h22);
    bus.wb_valid = 1'b0;

    // Reset pulsed mid-stall
    drive(32'hFFB0_0093, 32'h120, 32'h0, 32'h0);
    tick();
    bus.ex_ready = 1'b0;
    tick();
    chk("pre_rst.valid", 32'(bus.ex_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk_ex("mid_rst", 1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("mid_rst.pc", bus.ex_pc, RST_PC);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.ex_ready = 1'b1;
    tick();
    chk("post_rst.valid", 32'(bus.ex_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
